nios_fprint_pll_rst_seq: RTL and testbench

Reset sequencer that sits directly downstream of the nios_fprint system PLL wrapper. It drives the PLL's rst input and consumes its asynchronous locked output. It qualifies lock over a stable window, then releases the system reset for the Nios fingerprinting subsystem. It also detects lock timeout and lock loss, and retries the PLL a bounded number of times before flagging failure. Runs entirely on the free-running 50 MHz reference clock, so it keeps operating while outclk_0 is absent.

---
 rtl/nios_fprint_pll_rst_seq.sv | 159 +++++++++++++++
 tb/tb_nios_fprint_pll_rst_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nios_fprint_pll_rst_seq.sv
// nios_fprint PLL reset sequencer: PLL reset pulses, lock qualify, retry/fail.
// Optional lock-loss counter port: NIOS_FPRINT_PLL_LOCK_LOSS_CNT_EN
module nios_fprint_pll_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17,
    parameter int RETRY_W             = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               soft_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count
`ifdef NIOS_FPRINT_PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]         lock_loss_count
`endif
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [1:0]           sync_q;
    logic                 lock_s;
    logic                 loss_evt;
    logic                 pll_rst_q, sys_rst_q, ready_q, fail_q;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge refclk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], locked};
    end

    // Next-state, counter and retry logic; soft_req overrides everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        loss_evt = (state_q == S_RUN) && !lock_s;
        if (soft_req) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_PLL_RST;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = S_PLL_RST;
                        retry_d = '0;
                    end
                end
                S_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == S_PLL_RST);
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

`ifdef NIOS_FPRINT_PLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    // Saturating count of RUN exits caused by lock loss
    always_ff @(posedge refclk) begin
        if (rst)
            loss_cnt_q <= '0;
        else if (loss_evt && loss_cnt_q != 8'hff)
            loss_cnt_q <= loss_cnt_q + 1'b1;
    end

    assign lock_loss_count = loss_cnt_q;
`else
    logic unused_loss;
    assign unused_loss = loss_evt;
`endif

endmodule

// File: tb/tb_nios_fprint_pll_rst_seq.sv
// Bench for nios_fprint_pll_rst_seq with short cycle parameters.
module tb_nios_fprint_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       soft_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [1:0] retry_count;
`ifdef NIOS_FPRINT_PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nios_fprint_pll_rst_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2),
        .CNT_W(17),
        .RETRY_W(2)
    ) dut (
        .refclk(clk),
        .rst(rst),
        .locked(locked),
        .soft_req(soft_req),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .fail(fail),
        .retry_count(retry_count)
`ifdef NIOS_FPRINT_PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_count(lock_loss_count)
`endif
    );

    typedef struct {
        logic       r;
        logic       lk;
        logic       sr;
        logic       p;
        logic       s;
        logic       rdy;
        logic       f;
        logic [1:0] rc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, lk, sr, p, s, rdy, f,
                                input logic [1:0] rc);
        vec_t v;
        v.r = r; v.lk = lk; v.sr = sr;
        v.p = p; v.s = s; v.rdy = rdy; v.f = f; v.rc = rc;
        tbl.push_back(v);
    endfunction

    task automatic step(input logic r, input logic lk, input logic sr);
        rst = r;
        locked = lk;
        soft_req = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic p, input logic s,
                       input logic rdy, input logic f, input logic [1:0] rc);
        n_vec++;
        if ({pll_rst, sys_rst, ready, fail, retry_count} !== {p, s, rdy, f, rc}) begin
            n_bad++;
            $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b fail=%b rc=%0d, want %b %b %b %b %0d",
                     nm, pll_rst, sys_rst, ready, fail, retry_count, p, s, rdy, f, rc);
        end
    endtask

    initial begin
        bit got;

        // Clean start: lock sampled at edge 5, RUN after edge 15
        add(1, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].lk, tbl[i].sr);
            chk($sformatf("clean[%0d]", i), tbl[i].p, tbl[i].s,
                tbl[i].rdy, tbl[i].f, tbl[i].rc);
        end

        // Lock loss from RUN, then relock
        step(0, 0, 0); chk("loss_m", 0, 0, 1, 0, 0);
        step(0, 0, 0); chk("loss_m1", 0, 0, 1, 0, 0);
        step(0, 0, 0); chk("loss_m2", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0); chk("loss_pll", 1, 1, 0, 0, 0);
        end
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0); chk("loss_relock", 0, 1, 0, 0, 0);
        end
        step(0, 1, 0); chk("loss_run", 0, 0, 1, 0, 0);
`ifdef NIOS_FPRINT_PLL_LOCK_LOSS_CNT_EN
        n_vec++;
        if (lock_loss_count !== 8'd1) begin
            n_bad++;
            $display("FAIL loss_cnt: got %0d want 1", lock_loss_count);
        end
`endif

        // soft_req while running restarts the sequence
        step(0, 1, 1); chk("soft_run", 1, 1, 0, 0, 0);
        step(0, 1, 0); chk("soft_run_pll", 1, 1, 0, 0, 0);

        // Lock glitch during qualification
        step(1, 0, 0); chk("gl_rst", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0); chk("gl_pll", 1, 1, 0, 0, 0);
        end
        step(0, 0, 0); chk("gl_wait", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0); chk("gl_hi", 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0); chk("gl_lo", 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0); chk("gl_requal", 0, 1, 0, 0, 0);
        end
        step(0, 1, 0); chk("gl_run", 0, 0, 1, 0, 0);

        // Timeout: three PLL pulses then FAIL
        step(1, 0, 0); chk("to_rst", 1, 1, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < (p == 0 ? 3 : 4); i++) begin
                step(0, 0, 0); chk($sformatf("to_pll%0d", p), 1, 1, 0, 0, 2'(p));
            end
            for (int i = 0; i < 32; i++) begin
                step(0, 0, 0); chk($sformatf("to_wait%0d", p), 0, 1, 0, 0, 2'(p));
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0); chk("to_fail", 0, 1, 0, 1, 2);
        end

        // Recovery from FAIL via soft_req
        step(0, 0, 1); chk("rec_soft", 1, 1, 0, 0, 0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(0, 1, 0);
            if (ready) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL rec_timeout: got ready=%b want 1 within 40 cycles", ready);
        end
        chk("rec_run", 0, 0, 1, 0, 0);

        // Reset asserted in STABLE at cnt=5
        step(1, 0, 0); chk("mr_rst0", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 0, 0); chk("mr_wait", 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        chk("mr_stable", 0, 1, 0, 0, 0);
        step(1, 1, 0); chk("mr_rst", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0); chk("mr_pll", 1, 1, 0, 0, 0);
        end
        step(0, 1, 0); chk("mr_pll_end", 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
